uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver; counterpart of the team's transmit shift register and Tx path. Samples an asynchronous `serial_i` line and recovers 8N1 frames (start bit, DW data bits LSB first, one stop bit) at a fixed clocks-per-bit rate. Each good byte is presented on `data_o` with a one-cycle `valid_o` strobe; framing errors raise a one-cycle `frame_err_o` strobe. The block sits at the UART pin boundary, feeding the receive-side consumer logic.

## Interface
- `DW`, default 8: data bits per frame.
- `CLKS_PER_BIT`, default 16: `clk_i` cycles per bit. Must be at least 4. `HALF = CLKS_PER_BIT/2`, using integer division.
- `clk_i`  in  1: single clock. All logic is on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-low.
- `serial_i`  in  1: asynchronous serial line. Idles high.
- `data_o`  out  DW: last good received byte. Holds its value until the next good frame.
- `valid_o`  out  1: one-cycle pulse; `data_o` is updated in the same cycle.
- `frame_err_o`  out  1: one-cycle pulse when the stop bit is sampled low.
- `busy_o`  out  1: high in every state except IDLE.

## Operation
- **Input synchronizer**
  - `serial_i` passes through a 2-flop synchronizer to give `rx_s`.
  - The synchronizer flops reset to 1.
  - The FSM only ever sees `rx_s`.
- **Internal registers**
  - Cycle counter `cnt`, width clog2(CLKS_PER_BIT).
  - Bit index `idx`, width clog2(DW).
  - Shift register `sh`, width DW.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:**
    - If `rx_s` == 0: go to START, `cnt` <= 0.
  - **START:**
    - Each cycle: `cnt`++.
    - When `cnt` == HALF-1, sample `rx_s`:
      - 0 (valid start): go to DATA, `cnt` <= 0, `idx` <= 0.
      - 1 (glitch): go to IDLE. No output pulse.
  - **DATA:**
    - Each cycle: `cnt`++.
    - When `cnt` == CLKS_PER_BIT-1:
      - `sh` <= {`rx_s`, `sh`[DW-1:1]} (LSB arrives first).
      - `cnt` <= 0.
      - If `idx` == DW-1, go to STOP; otherwise `idx`++.
  - **STOP:**
    - Each cycle: `cnt`++.
    - When `cnt` == CLKS_PER_BIT-1:
      - `rx_s` == 1: `data_o` <= `sh`, `valid_o` <= 1, go to IDLE.
      - `rx_s` == 0: `frame_err_o` <= 1, `data_o` unchanged, go to BREAK.
  - **BREAK:**
    - Stay until `rx_s` == 1, then go to IDLE.
    - This prevents a held-low line (break condition) from being decoded as back-to-back 0x00 frames.
- **Output strobes**
  - `valid_o` and `frame_err_o` default to 0 every cycle.
  - They are never high together.
- **Back-to-back frames**
  - A start bit immediately following a good stop sample is accepted.
  - IDLE sees `rx_s` low on the next cycle with no dead time.
- **Noise rejection**
  - Sampling is a single point at mid-bit.
  - There is no majority vote.
- **Reset**
  - `rst_i` low at a clock edge forces:
    - state IDLE;
    - `cnt`, `idx`, `sh` = 0;
    - `data_o` = 0, `valid_o` = 0, `frame_err_o` = 0, `busy_o` = 0;
    - synchronizer flops = 1.
  - Reset mid-frame abandons the frame with no strobe.
  - After reset releases, reception resumes at the next falling edge of `rx_s`.

## Timing
- **Synchronizer latency:** 2 cycles.
- **Edge numbering:** edge E1 is the first `clk_i` rising edge after `serial_i` falls.
  - START is entered at E3.
  - DATA is entered at E(3+HALF).
  - STOP is entered at E(3+HALF+DW·CLKS_PER_BIT).
  - `valid_o` is registered high at E(3+HALF+(DW+1)·CLKS_PER_BIT).
  - With the defaults (DW=8, CLKS_PER_BIT=16), `valid_o` goes high at E155 and stays high for exactly 1 cycle.
- **Data sample points:** bit k is sampled at E(3+HALF+(k+1)·CLKS_PER_BIT), which is the synchronized mid-bit ±1 cycle.
- **`busy_o`:** registered as a function of state.
  - Rises the cycle after E3.
  - Falls in the same cycle `valid_o` rises.
- **Tolerance:** the receiver accepts a transmitter baud error of up to ±(HALF-3)/(CLKS_PER_BIT·(DW+1)) relative.

## Test plan
- **Reset values:** hold `rst_i`=0 for 3 cycles with `serial_i`=1.
  - Required: all outputs 0, `busy_o`=0.
  - Release reset and idle for 50 cycles: no strobes.
- **Good frame:** send 0xA5 with CLKS_PER_BIT=16 (line bits 0, 1,0,1,0,0,1,0,1, 1).
  - Required: `valid_o` high for exactly one cycle at E155, `data_o`=0xA5, `frame_err_o` never asserted.
- **Back-to-back frames:** send 0x00, 0xFF, 0x3C with no idle between frames.
  - Required: three `valid_o` pulses spaced exactly 160 cycles apart, with `data_o` = 0x00, 0xFF, 0x3C in order.
- **Start-bit glitch:** drive `serial_i` low for 4 cycles, then high.
  - Required: `busy_o` pulses; `valid_o` and `frame_err_o` stay 0; FSM returns to IDLE.
  - A following 0x5A frame is received correctly.
- **Framing error:** send 0x81 with the stop bit low, then hold the line low for 40 more cycles, then high.
  - Required: one `frame_err_o` pulse, `data_o` keeps its previous value, no further strobes while low.
  - A following 0x81 frame is received correctly.
- **Reset mid-frame:** assert `rst_i` during data bit 3 of 0x77.
  - Required: no strobe, outputs reset.
  - Resending 0x77 after release produces `data_o`=0x77 with a single `valid_o`.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a fixed clocks-per-bit rate.
// The line is double-flopped, sampled at mid-bit from the start edge, and
// each byte is reported with a one-cycle valid or framing-error strobe.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s to go low
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling DW data bits, LSB first, one per bit period
// STOP  | sampling the stop bit, then reporting the byte or a framing error
// BREAK | stop bit was low; wait for the line to return high

module uart_rx #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          serial_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          frame_err_o,
  output logic          busy_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] sh;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i) begin
    if (!rst_i) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_i};
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (cnt == CNT_HALF) state_next = rx_s ? IDLE : DATA;
      DATA:    if (cnt == CNT_LAST && idx == IDX_LAST) state_next = STOP;
      STOP:    if (cnt == CNT_LAST) state_next = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy is a pure decode of the registered state.
  always_comb begin
    busy_o = (state != IDLE);
  end

  // Bit timing, shift register and output strobes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: cnt <= '0;
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            sh  <= {rx_s, sh[DW-1:1]};
            cnt <= '0;
            if (idx != IDX_LAST) idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_o  <= sh;
              valid_o <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK:   cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule
